// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: decodes DDR4 CA pins into per-bank-group command strobes
// and tracks per-bank open/row state so RD/WR strobes carry the open row.
// Ports: clk, rst (sync, active-low), cke, cs_n/act_n/ras_n/cas_n/we_n,
//   bg, ba_in, addr[13:0] in; ACT/PR/PRA/RD/RDA/WR/WRA/REF/MRW strobes,
//   CKEH/CKEL, ba, row, column, err, err_code out (all registered).
// Optional: define CMD_ILLEGAL_CHECK_EN to suppress and flag illegal commands.
module ddr_cmd_decoder #(
  parameter int BANKGROUPS = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int ADDRWIDTH = 17,
  parameter int COLS = 1024,
  localparam int CW = $clog2(COLS),
  localparam int BGW = $clog2(BANKGROUPS),
  localparam int BAW = $clog2(BANKSPERGROUP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  act_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BGW-1:0]        bg,
  input  logic [BAW-1:0]        ba_in,
  input  logic [13:0]           addr,
  output logic [BANKGROUPS-1:0] ACT,
  output logic [BANKGROUPS-1:0] PR,
  output logic [BANKGROUPS-1:0] PRA,
  output logic [BANKGROUPS-1:0] RD,
  output logic [BANKGROUPS-1:0] RDA,
  output logic [BANKGROUPS-1:0] WR,
  output logic [BANKGROUPS-1:0] WRA,
  output logic [BANKGROUPS-1:0] REF,
  output logic [BANKGROUPS-1:0] MRW,
  output logic                  CKEH,
  output logic                  CKEL,
  output logic [BAW-1:0]        ba,
  output logic [ADDRWIDTH-1:0]  row,
  output logic [CW-1:0]         column,
  output logic                  err,
  output logic [1:0]            err_code
);

`ifdef CMD_ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int IW = BGW + BAW;
  localparam int NB = 1 << IW;

  logic                 cke_q;
  logic [NB-1:0]        open_q;
  logic [ADDRWIDTH-1:0] rows_q [NB];

  logic                  live;
  logic [IW-1:0]         idx;
  logic [16:0]           act_raw;
  logic [ADDRWIDTH-1:0]  act_row;
  logic [ADDRWIDTH-1:0]  cur_row;
  logic [BANKGROUPS-1:0] sel;
  logic [2:0]            rcw;
  logic                  hit;
  logic                  any_open;
  logic is_act, is_mrw, is_ref, is_pr, is_wr, is_rd;

  assign live     = !cs_n && cke_q;
  assign idx      = {bg, ba_in};
  // During ACT the ras/cas/we pins are row bits A16..A14.
  assign act_raw  = {ras_n, cas_n, we_n, addr};
  assign act_row  = ADDRWIDTH'(act_raw);
  assign cur_row  = rows_q[idx];
  assign sel      = BANKGROUPS'(1) << bg;
  assign rcw      = {ras_n, cas_n, we_n};
  assign hit      = open_q[idx];
  assign any_open = |open_q;

  assign is_act = live && !act_n;
  assign is_mrw = live && act_n && (rcw == 3'b000);
  assign is_ref = live && act_n && (rcw == 3'b001);
  assign is_pr  = live && act_n && (rcw == 3'b010);
  assign is_wr  = live && act_n && (rcw == 3'b100);
  assign is_rd  = live && act_n && (rcw == 3'b101);

  logic [BANKGROUPS-1:0] n_act, n_pr, n_pra, n_rd, n_rda;
  logic [BANKGROUPS-1:0] n_wr, n_wra, n_ref, n_mrw;
  logic [ADDRWIDTH-1:0]  n_row;
  logic [CW-1:0]         n_col;
  logic                  n_err;
  logic [1:0]            n_code;
  logic                  t_set, t_clr, t_clr_all;

  always_comb begin
    n_act     = '0;
    n_pr      = '0;
    n_pra     = '0;
    n_rd      = '0;
    n_rda     = '0;
    n_wr      = '0;
    n_wra     = '0;
    n_ref     = '0;
    n_mrw     = '0;
    n_row     = '0;
    n_col     = '0;
    n_err     = 1'b0;
    n_code    = 2'd0;
    t_set     = 1'b0;
    t_clr     = 1'b0;
    t_clr_all = 1'b0;
    unique case (1'b1)
      is_act: begin
        if (CHK && hit) begin
          n_err  = 1'b1;
          n_code = 2'd0;
        end else begin
          n_act = sel;
          n_row = act_row;
          t_set = 1'b1;
        end
      end
      is_pr: begin
        if (addr[10]) begin
          n_pra     = '1;
          t_clr_all = 1'b1;
        end else begin
          n_pr  = sel;
          t_clr = 1'b1;
        end
      end
      is_rd: begin
        if (CHK && !hit) begin
          n_err  = 1'b1;
          n_code = 2'd1;
        end else begin
          n_row = cur_row;
          n_col = addr[CW-1:0];
          if (addr[10]) begin
            n_rda = sel;
            t_clr = 1'b1;
          end else begin
            n_rd = sel;
          end
        end
      end
      is_wr: begin
        if (CHK && !hit) begin
          n_err  = 1'b1;
          n_code = 2'd1;
        end else begin
          n_row = cur_row;
          n_col = addr[CW-1:0];
          if (addr[10]) begin
            n_wra = sel;
            t_clr = 1'b1;
          end else begin
            n_wr = sel;
          end
        end
      end
      is_ref: begin
        if (CHK && any_open) begin
          n_err  = 1'b1;
          n_code = 2'd2;
        end else begin
          n_ref = '1;
        end
      end
      is_mrw: begin
        if (CHK && any_open) begin
          n_err  = 1'b1;
          n_code = 2'd2;
        end else begin
          n_mrw = '1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cke_q    <= 1'b0;
      open_q   <= '0;
      for (int i = 0; i < NB; i++) rows_q[i] <= '0;
      ACT      <= '0;
      PR       <= '0;
      PRA      <= '0;
      RD       <= '0;
      RDA      <= '0;
      WR       <= '0;
      WRA      <= '0;
      REF      <= '0;
      MRW      <= '0;
      CKEH     <= 1'b0;
      CKEL     <= 1'b0;
      ba       <= '0;
      row      <= '0;
      column   <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      cke_q    <= cke;
      ACT      <= n_act;
      PR       <= n_pr;
      PRA      <= n_pra;
      RD       <= n_rd;
      RDA      <= n_rda;
      WR       <= n_wr;
      WRA      <= n_wra;
      REF      <= n_ref;
      MRW      <= n_mrw;
      CKEH     <= !cke_q && cke;
      CKEL     <= cke_q && !cke;
      ba       <= ba_in;
      row      <= n_row;
      column   <= n_col;
      err      <= n_err;
      err_code <= n_code;
      if (t_clr_all) begin
        open_q <= '0;
      end else if (t_set) begin
        open_q[idx] <= 1'b1;
        rows_q[idx] <= act_row;
      end else if (t_clr) begin
        open_q[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb_ddr_cmd_decoder: scoreboard bench for ddr_cmd_decoder.
// Expectations queued with stimulus, popped one cycle later.
module tb_ddr_cmd_decoder;

`ifdef CMD_ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0] bg, ba_in;
  logic [13:0] addr;
  logic [3:0] ACT, PR, PRA, RD, RDA, WR, WRA, REF, MRW;
  logic CKEH, CKEL, err;
  logic [1:0] ba, err_code;
  logic [16:0] row;
  logic [9:0] column;

  ddr_cmd_decoder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg),
    .ba_in(ba_in), .addr(addr), .ACT(ACT), .PR(PR), .PRA(PRA),
    .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .REF(REF), .MRW(MRW),
    .CKEH(CKEH), .CKEL(CKEL), .ba(ba), .row(row), .column(column),
    .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic rst, cke, cs_n, act_n;
    logic [2:0] rcw;
    logic [1:0] bg, ba;
    logic [13:0] addr;
  } pin_t;

  typedef struct packed {
    logic [3:0] act, pr, pra, rd, rda, wr, wra, rf, mrw;
    logic ckeh, ckel;
    logic [1:0] ba;
    logic [16:0] row;
    logic [9:0] col;
    logic err;
    logic [1:0] code;
  } exp_t;

  pin_t stim_q[$];
  exp_t sb[$];
  int n_vec = 0;
  int n_miss = 0;

  function automatic pin_t pin(logic csn, logic actn, logic [2:0] rcw,
                               logic [1:0] g, logic [1:0] b,
                               logic [13:0] a);
    pin_t p;
    p.rst = 1'b1; p.cke = 1'b1; p.cs_n = csn; p.act_n = actn;
    p.rcw = rcw; p.bg = g; p.ba = b; p.addr = a;
    return p;
  endfunction

  function automatic pin_t p_idle();
    return pin(1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'd0);
  endfunction

  function automatic pin_t p_act(logic [1:0] g, logic [1:0] b,
                                 logic [16:0] r);
    return pin(1'b0, 1'b0, r[16:14], g, b, r[13:0]);
  endfunction

  function automatic pin_t p_cmd(logic [2:0] rcw, logic [1:0] g,
                                 logic [1:0] b, logic [13:0] a);
    return pin(1'b0, 1'b1, rcw, g, b, a);
  endfunction

  function automatic exp_t ex(logic [1:0] b);
    exp_t e = '0;
    e.ba = b;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.act = ACT; o.pr = PR; o.pra = PRA; o.rd = RD; o.rda = RDA;
    o.wr = WR; o.wra = WRA; o.rf = REF; o.mrw = MRW;
    o.ckeh = CKEH; o.ckel = CKEL; o.ba = ba; o.row = row;
    o.col = column; o.err = err; o.code = err_code;
    return o;
  endfunction

  task automatic add(input pin_t p, input exp_t e);
    stim_q.push_back(p);
    sb.push_back(e);
  endtask

  task automatic apply(input pin_t p);
    rst = p.rst; cke = p.cke; cs_n = p.cs_n; act_n = p.act_n;
    {ras_n, cas_n, we_n} = p.rcw;
    bg = p.bg; ba_in = p.ba; addr = p.addr;
  endtask

  task automatic test_reset();
    pin_t p;
    exp_t e, x, g;
    p = p_idle(); p.rst = 1'b0;
    add(p, ex(0));
    e = ex(0); e.ckeh = 1'b1;
    add(p_idle(), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL reset v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_act_rd();
    exp_t e, x, g;
    e = ex(2); e.act = 4'b0010; e.row = 17'h5;
    add(p_act(2'd1, 2'd2, 17'h00005), e);
    add(p_idle(), ex(0));
    e = ex(2); e.rd = 4'b0010; e.row = 17'h5; e.col = 10'h7;
    add(p_cmd(3'b101, 2'd1, 2'd2, 14'h0007), e);
    e = ex(2); e.rda = 4'b0010; e.row = 17'h5; e.col = 10'h7;
    add(p_cmd(3'b101, 2'd1, 2'd2, 14'h0407), e);
    e = ex(2);
    if (CHK) begin
      e.err = 1'b1; e.code = 2'd1;
    end else begin
      e.rd = 4'b0010; e.row = 17'h5; e.col = 10'h7;
    end
    add(p_cmd(3'b101, 2'd1, 2'd2, 14'h0007), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL act_rd v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, x, g;
    e = ex(3); e.act = 4'b1000; e.row = 17'h1ABCD;
    add(p_act(2'd3, 2'd3, 17'h1ABCD), e);
    e = ex(3); e.wr = 4'b1000; e.row = 17'h1ABCD; e.col = 10'h3FF;
    add(p_cmd(3'b100, 2'd3, 2'd3, 14'h03FF), e);
    e = ex(3); e.wra = 4'b1000; e.row = 17'h1ABCD; e.col = 10'h055;
    add(p_cmd(3'b100, 2'd3, 2'd3, 14'h0455), e);
    add(p_cmd(3'b011, 2'd3, 2'd3, 14'h0), ex(3));
    add(p_cmd(3'b110, 2'd3, 2'd3, 14'h0), ex(3));
    add(pin(1'b1, 1'b0, 3'b000, 2'd3, 2'd1, 14'h1), ex(1));
    e = ex(3); e.pr = 4'b1000;
    add(p_cmd(3'b010, 2'd3, 2'd3, 14'h0), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL b2b v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_pra_ref();
    exp_t e, x, g;
    e = ex(0); e.act = 4'b0001; e.row = 17'h3;
    add(p_act(2'd0, 2'd0, 17'h3), e);
    e = ex(0); e.pra = 4'b1111;
    add(p_cmd(3'b010, 2'd0, 2'd0, 14'h0400), e);
    e = ex(1); e.rf = 4'b1111;
    add(p_cmd(3'b001, 2'd2, 2'd1, 14'h0), e);
    e = ex(3); e.mrw = 4'b1111;
    add(p_cmd(3'b000, 2'd1, 2'd3, 14'h0123), e);
    e = ex(1); e.act = 4'b0001; e.row = 17'h9;
    add(p_act(2'd0, 2'd1, 17'h9), e);
    e = ex(0);
    if (CHK) begin
      e.err = 1'b1; e.code = 2'd2;
    end else begin
      e.rf = 4'b1111;
    end
    add(p_cmd(3'b001, 2'd0, 2'd0, 14'h0), e);
    e = ex(1); e.pr = 4'b0001;
    add(p_cmd(3'b010, 2'd0, 2'd1, 14'h0), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL pra_ref v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_double_act();
    exp_t e, x, g;
    e = ex(1); e.act = 4'b0100; e.row = 17'h11;
    add(p_act(2'd2, 2'd1, 17'h11), e);
    e = ex(1);
    if (CHK) begin
      e.err = 1'b1; e.code = 2'd0;
    end else begin
      e.act = 4'b0100; e.row = 17'h22;
    end
    add(p_act(2'd2, 2'd1, 17'h22), e);
    e = ex(1); e.rd = 4'b0100; e.col = 10'h1;
    e.row = CHK ? 17'h11 : 17'h22;
    add(p_cmd(3'b101, 2'd2, 2'd1, 14'h0001), e);
    e = ex(1); e.pr = 4'b0100;
    add(p_cmd(3'b010, 2'd2, 2'd1, 14'h0), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL dbl_act v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_cke();
    pin_t p;
    exp_t e, x, g;
    p = p_idle(); p.cke = 1'b0;
    e = ex(0); e.ckel = 1'b1;
    add(p, e);
    p = p_act(2'd0, 2'd2, 17'h1); p.cke = 1'b0;
    add(p, ex(2));
    e = ex(2); e.ckeh = 1'b1;
    add(p_act(2'd0, 2'd2, 17'h1), e);
    e = ex(2);
    if (CHK) begin
      e.err = 1'b1; e.code = 2'd1;
    end else begin
      e.rd = 4'b0001; e.col = 10'h5;
    end
    add(p_cmd(3'b101, 2'd0, 2'd2, 14'h0005), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL cke v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  task automatic test_reset_traffic();
    pin_t p;
    exp_t e, x, g;
    e = ex(1); e.act = 4'b0010; e.row = 17'h77;
    add(p_act(2'd1, 2'd1, 17'h77), e);
    p = p_act(2'd1, 2'd1, 17'h77); p.rst = 1'b0;
    add(p, ex(0));
    e = ex(0); e.ckeh = 1'b1;
    add(p_idle(), e);
    e = ex(1);
    if (CHK) begin
      e.err = 1'b1; e.code = 2'd1;
    end else begin
      e.rd = 4'b0010; e.col = 10'h4;
    end
    add(p_cmd(3'b101, 2'd1, 2'd1, 14'h0004), e);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      x = sb.pop_front(); g = obs(); n_vec++;
      if (g !== x) begin
        n_miss++;
        $display("FAIL rst_traffic v%0d got=%h exp=%h", n_vec, g, x);
      end
    end
  endtask

  initial begin
    apply(p_idle());
    rst = 1'b0;
    test_reset();
    test_act_rd();
    test_back_to_back();
    test_pra_ref();
    test_double_act();
    test_cke();
    test_reset_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_decoder.md
# ddr_cmd_decoder

Command decoder and bank-state tracker that sits directly upstream of the BankGroup instances in the DDR emulation path. It samples the DDR4 command/address pins each cycle, decodes them into one-cycle command strobes (ACT, PR, PRA, RD, RDA, WR, WRA, REF, MRW, CKEH, CKEL), and routes bank-specific strobes to the addressed bank group. It also keeps a per-bank open/closed table with the open row, so RD/WR strobes carry the correct row alongside the column.

## Interface
- BANKGROUPS, 4, number of bank groups driven
- BANKSPERGROUP, 4, banks per group
- ADDRWIDTH, 17, row address width (A[16:0])
- COLS, 1024, columns per row; column width CW = $clog2(COLS)
- BGW / BAW, derived: $clog2(BANKGROUPS) / $clog2(BANKSPERGROUP)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- cke  in  1  clock enable pin
- cs_n, act_n, ras_n, cas_n, we_n  in  1 each  DDR4 command pins (ras_n/cas_n/we_n double as A16/A15/A14 during ACT)
- bg  in  BGW  bank group address
- ba_in  in  BAW  bank address
- addr  in  14  A[13:0] (A10 = auto-precharge / all-banks flag)
- ACT, PR, PRA, RD, RDA, WR, WRA, REF, MRW  out  BANKGROUPS each  one-hot-per-group strobes (REF, MRW, PRA asserted on all groups)
- CKEH, CKEL  out  1 each  CKE rising / falling strobes
- ba  out  BAW  registered bank address
- row  out  ADDRWIDTH  ACT: new row; RD/WR(A): open row of addressed bank; else 0
- column  out  CW  addr[CW-1:0] on RD/WR(A); else 0
- err  out  1  one-cycle illegal-command pulse
- err_code  out  2  0 ACT-to-open, 1 access-to-closed, 2 REF/MRW with bank open, 3 reserved

## Operation
- Decode only when cs_n=0 and cke_q=1 (cke_q = cke registered last cycle). act_n=0 → ACT, row = {~ras_n… raw pins: ras_n, cas_n, we_n, addr[13:0]}.
- act_n=1, {ras_n,cas_n,we_n}: 000 MRW; 001 REF; 010 PR (A10=0) / PRA (A10=1); 100 WR/WRA; 101 RD/RDA (A10 selects auto-precharge); 011, 110, 111 → no strobe.
- cs_n=1 → deselect, no strobe. CKEH when cke_q=0, cke=1; CKEL when cke_q=1, cke=0; commands ignored while cke_q=0.
- Bank table (BANKGROUPS×BANKSPERGROUP entries: open bit + row): ACT sets open and stores row; PR clears addressed bank; PRA clears all; RDA/WRA clear addressed bank in the same update that issues the strobe.
- Bank-specific strobes appear only on bit bg of the vector; all others 0.

## Timing
- Reset (rst=0 at edge): every strobe, CKEH, CKEL, err = 0; ba, row, column, err_code = 0; table all closed, rows 0; cke_q = 0.
- Latency: pins sampled at edge N → strobe/ba/row/column valid after edge N, held exactly one cycle, back-to-back commands produce back-to-back strobes.
- RD/WR following ACT on the same bank in the next cycle reads the row written by that ACT (table write-through).
- Reset during traffic discards the in-flight command; first post-reset command sees all banks closed.
- Row width is ADDRWIDTH; addr bits above CW ignored for column except A10 flag.

## Configuration
- CMD_ILLEGAL_CHECK_EN defined: ACT to open bank, RD/WR(A) to closed bank, REF/MRW with any bank open → strobe suppressed, table unchanged, err=1 with err_code for one cycle.
- Undefined: all decoded commands forwarded; ACT to open bank overwrites stored row; RD to closed bank outputs stored (stale) row; err and err_code tied 0.

## Test plan
- Reset then cs_n=0, act_n=0, bg=1, ba_in=2, {ras_n,cas_n,we_n,addr}=17'h00005 → next cycle ACT=4'b0010, ba=2, row=5, one cycle only.
- Following RD bg=1, ba_in=2, addr=14'h0007 → RD=4'b0010, row=5, column=7; RDA variant (A10=1) then RD to same bank → with macro err=1, err_code=1, RD=0.
- ACT bg=0/ba 0 row 3, PRA → PRA=4'b1111; subsequent REF → REF=4'b1111, err=0.
- Macro on: ACT twice to bg=2, ba 1 → second ACT suppressed, err_code=0; macro off → second ACT forwarded, new row stored.
- cke 1→0 → CKEL pulse; ACT issued while cke_q=0 → no strobe; cke 0→1 → CKEH pulse.
- rst=0 asserted cycle after ACT, released, RD same bank → all outputs 0 during reset; RD flagged access-to-closed (macro on).
